input_port_router: RTL and testbench
====================================

// Module: input_port_router
// PURPOSE
//  Input stage of one router port. Captures packets arriving on the link into a DEPTH-entry FIFO.
//  Makes a dimension-ordered (X then Y) routing decision for the head packet.
//  Presents the head packet, with a one-hot select, to the four outputPortArbiters (N/S/E/W) or to the local cache arbiter.
//  Pops the head only when the chosen consumer accepts it; asserts back-pressure upstream when full.
// PARAMETERS
//  ADDR_W  4   network address width; upper ADDR_W/2 bits = X, lower ADDR_W/2 bits = Y
//  BANK_W  4   cache bank address width (low bits of the destination field)
//  DATA_W  32  payload width
//  DEPTH   4   FIFO entries (power of 2, >=2)
//  MY_X    0   this router's X coordinate
//  MY_Y    0   this router's Y coordinate
// PORTS
//  clk                    in   1              single clock; all state changes on posedge
//  reset                  in   1              synchronous, active-low
//  readIn                 in   1              link packet is a read
//  writeIn                in   1              link packet is a write
//  destinationAddressIn   in   ADDR_W+BANK_W  {network addr, bank addr}
//  requesterAddressIn     in   ADDR_W         originator address
//  dataIn                 in   DATA_W         payload
//  stallOut               out  1              to upstream: FIFO full, packet this cycle not taken
//  selectBit_NORTH/SOUTH/EAST/WEST/LOCAL  out 1 each  one-hot route of head packet
//  acceptIn               in   1              selected consumer takes the head this cycle
//  destinationAddressOut  out  ADDR_W+BANK_W  head fields, valid while any select is high
//  requesterAddressOut    out  ADDR_W
//  readOut                out  1
//  writeOut               out  1
//  dataOut                out  DATA_W
//  errorOut               out  1              sticky: dropped packet (overflow or read&write both set)
// BEHAVIOUR
//  - Push: push = (readIn ^ writeIn) & ~full. Fields are written at wr_ptr; wr_ptr increments mod DEPTH.
//  - Illegal packet: readIn & writeIn is never stored and sets errorOut.
//  - Pop: pop = ~empty & acceptIn & (any select high); rd_ptr increments mod DEPTH.
//    acceptIn is ignored while empty.
//  - count: width clog2(DEPTH)+1.
//    full = (count==DEPTH); empty = (count==0); stallOut = full (registered state, no comb path from inputs).
//  - Simultaneous push and pop:
//    - not full: both happen, count unchanged.
//    - full: push is refused even though a slot frees, errorOut sets if a packet was present, the pop proceeds.
//  - Wrap-around: pointers wrap DEPTH-1 -> 0 with no bubble; entry order is strictly FIFO.
//  - Routing (combinational on the head entry; all selects 0 when empty). dX/dY = destination X/Y fields.
//    - dX > MY_X -> EAST; dX < MY_X -> WEST.
//    - else dY > MY_Y -> SOUTH; dY < MY_Y -> NORTH.
//    - else LOCAL.
//  - Latency: a packet pushed on edge k is visible (select high) after edge k if the FIFO was empty.
//    Minimum 1 cycle link-to-select.
//  - The head is held stable (all outputs) until popped; no head-of-line reordering.
//  - Reset (reset==0 at posedge) overrides push and pop:
//    - rd_ptr = wr_ptr = count = 0; errorOut = 0; stallOut = 0; all selects 0.
//    - readOut = writeOut = 0; data/address outputs 0.
//  - Reset mid-operation flushes all entries; no partial packet survives.
// TESTING
//  1. MY_X=1,MY_Y=1; push write dest {x=2,y=1}, acceptIn=1 -> selectBit_EAST=1 one cycle after push, popped next edge, empty.
//  2. Push dests {0,1},{1,0},{1,2},{1,1} with acceptIn=0 -> WEST first; stallOut=1 after 4th push (DEPTH=4).
//     Then accept one per cycle -> order W,N,S,LOCAL.
//  3. Full FIFO, 5th packet with acceptIn=0 -> stallOut=1, packet dropped, errorOut=1.
//     Same with acceptIn=1 -> head pops, new packet still dropped.
//  4. readIn=1 & writeIn=1 on empty FIFO -> count stays 0, all selects 0, errorOut=1.
//  5. Stream 10 packets data=0..9, acceptIn=1 every cycle -> dataOut sequence 0..9, pointers wrap twice, stallOut never 1.
//  6. 3 entries queued, reset=0 for one edge -> next cycle empty, all selects 0, errorOut=0.
//     First push after release appears at head.

Source files
------------

// File: rtl/input_port_router_if.sv
// rtl/input_port_router_if.sv - link-side and consumer-side signal bundle of one router input port
interface input_port_router_if #(
    parameter int ADDR_W = 4,
    parameter int BANK_W = 4,
    parameter int DATA_W = 32
);
    logic                     readIn;
    logic                     writeIn;
    logic [ADDR_W+BANK_W-1:0] destinationAddressIn;
    logic [ADDR_W-1:0]        requesterAddressIn;
    logic [DATA_W-1:0]        dataIn;
    logic                     stallOut;

    logic                     selectBit_NORTH;
    logic                     selectBit_SOUTH;
    logic                     selectBit_EAST;
    logic                     selectBit_WEST;
    logic                     selectBit_LOCAL;
    logic                     acceptIn;
    logic [ADDR_W+BANK_W-1:0] destinationAddressOut;
    logic [ADDR_W-1:0]        requesterAddressOut;
    logic                     readOut;
    logic                     writeOut;
    logic [DATA_W-1:0]        dataOut;
    logic                     errorOut;

    modport slave (
        input  readIn, writeIn, destinationAddressIn, requesterAddressIn, dataIn, acceptIn,
        output stallOut, selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST,
               selectBit_LOCAL, destinationAddressOut, requesterAddressOut, readOut, writeOut,
               dataOut, errorOut
    );

    modport master (
        output readIn, writeIn, destinationAddressIn, requesterAddressIn, dataIn, acceptIn,
        input  stallOut, selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST,
               selectBit_LOCAL, destinationAddressOut, requesterAddressOut, readOut, writeOut,
               dataOut, errorOut
    );
endinterface

// File: rtl/input_port_router.sv
// rtl/input_port_router.sv - router input FIFO with dimension-ordered (X then Y) head routing
module input_port_router #(
    parameter int ADDR_W = 4,
    parameter int BANK_W = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input_port_router_if.slave  port
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DEST_W = ADDR_W + BANK_W;
    localparam int HW     = ADDR_W / 2;
    localparam logic [HW-1:0]    MY_X_L = HW'(MY_X);
    localparam logic [HW-1:0]    MY_Y_L = HW'(MY_Y);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEST_W-1:0] dest_mem_q [DEPTH];
    logic [ADDR_W-1:0] req_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic              wr_mem_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;

    logic full, empty, head_valid, pkt_legal, pkt_illegal, push, pop, any_sel;
    logic sel_n, sel_s, sel_e, sel_w, sel_l;
    logic [DEST_W-1:0] head_dest;
    logic [HW-1:0]     dx, dy;

    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign head_valid  = ~empty;
    assign pkt_legal   = port.readIn ^ port.writeIn;
    assign pkt_illegal = port.readIn & port.writeIn;
    // A full FIFO refuses the push even when the head pops this same cycle.
    assign push        = pkt_legal & ~full;
    assign pop         = head_valid & port.acceptIn & any_sel;

    assign head_dest = dest_mem_q[rd_ptr_q];
    assign dx        = head_dest[DEST_W-1 -: HW];
    assign dy        = head_dest[BANK_W +: HW];

    always_comb begin
        sel_n = 1'b0;
        sel_s = 1'b0;
        sel_e = 1'b0;
        sel_w = 1'b0;
        sel_l = 1'b0;
        if (head_valid) begin
            if (dx > MY_X_L)      sel_e = 1'b1;
            else if (dx < MY_X_L) sel_w = 1'b1;
            else if (dy > MY_Y_L) sel_s = 1'b1;
            else if (dy < MY_Y_L) sel_n = 1'b1;
            else                  sel_l = 1'b1;
        end
    end
    assign any_sel = sel_n | sel_s | sel_e | sel_w | sel_l;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        error_d = error_q | pkt_illegal | (pkt_legal & full);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // Storage needs no reset: head outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            dest_mem_q[wr_ptr_q] <= port.destinationAddressIn;
            req_mem_q[wr_ptr_q]  <= port.requesterAddressIn;
            data_mem_q[wr_ptr_q] <= port.dataIn;
            wr_mem_q[wr_ptr_q]   <= port.writeIn;
        end
    end

    assign port.stallOut              = full;
    assign port.errorOut              = error_q;
    assign port.selectBit_NORTH       = sel_n;
    assign port.selectBit_SOUTH       = sel_s;
    assign port.selectBit_EAST        = sel_e;
    assign port.selectBit_WEST        = sel_w;
    assign port.selectBit_LOCAL       = sel_l;
    assign port.destinationAddressOut = head_valid ? head_dest : '0;
    assign port.requesterAddressOut   = head_valid ? req_mem_q[rd_ptr_q] : '0;
    assign port.dataOut               = head_valid ? data_mem_q[rd_ptr_q] : '0;
    assign port.writeOut              = head_valid & wr_mem_q[rd_ptr_q];
    assign port.readOut               = head_valid & ~wr_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_input_port_router.sv
// tb/tb_input_port_router.sv - directed self-checking bench for input_port_router (MY_X=1, MY_Y=1)
module tb_input_port_router;
    localparam logic [4:0] SN = 5'b10000, SS = 5'b01000, SE = 5'b00100,
                           SW = 5'b00010, SL = 5'b00001, S0 = 5'b00000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    input_port_router_if #(.ADDR_W(4), .BANK_W(4), .DATA_W(32)) bus ();

    input_port_router #(
        .ADDR_W(4), .BANK_W(4), .DATA_W(32), .DEPTH(4), .MY_X(1), .MY_Y(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .port  (bus.slave)
    );

    logic [4:0] sel;
    assign sel = {bus.selectBit_NORTH, bus.selectBit_SOUTH, bus.selectBit_EAST,
                  bus.selectBit_WEST, bus.selectBit_LOCAL};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input int x, input int y,
                         input logic [31:0] d, input logic acc);
        logic [7:0] dest;
        dest = {x[1:0], y[1:0], 4'h3};
        bus.readIn               = rd;
        bus.writeIn              = wr;
        bus.destinationAddressIn = dest;
        bus.requesterAddressIn   = 4'h9;
        bus.dataIn               = d;
        bus.acceptIn             = acc;
    endtask

    task automatic idle(input logic acc);
        drive(1'b0, 1'b0, 0, 0, 32'h0, acc);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        idle(1'b0);
        step();
        step();
        reset = 1'b1;
        check("rst_sel", sel, S0);
        check("rst_stall", bus.stallOut, 1'b0);
        check("rst_err", bus.errorOut, 1'b0);
        check("rst_data", bus.dataOut, 32'h0);
        check("rst_rdwr", {bus.readOut, bus.writeOut}, 2'b00);

        // single write routed east, popped on the following edge
        drive(1'b0, 1'b1, 2, 1, 32'hA5, 1'b1);
        step();
        check("t1_sel", sel, SE);
        check("t1_data", bus.dataOut, 32'hA5);
        check("t1_wr", {bus.readOut, bus.writeOut}, 2'b01);
        check("t1_dest", bus.destinationAddressOut, 8'b1001_0011);
        check("t1_req", bus.requesterAddressOut, 4'h9);
        idle(1'b1);
        step();
        check("t1_empty", sel, S0);

        // fill four entries, then drain in order W, N, S, LOCAL
        drive(1'b0, 1'b1, 0, 1, 32'd1, 1'b0);
        step();
        check("t2_first_w", sel, SW);
        drive(1'b1, 1'b0, 1, 0, 32'd2, 1'b0);
        step();
        drive(1'b0, 1'b1, 1, 2, 32'd3, 1'b0);
        step();
        check("t2_stall3", bus.stallOut, 1'b0);
        drive(1'b0, 1'b1, 1, 1, 32'd4, 1'b0);
        step();
        check("t2_stall4", bus.stallOut, 1'b1);
        check("t2_head_hold", bus.dataOut, 32'd1);
        idle(1'b1);
        step();
        check("t2_sel_n", sel, SN);
        check("t2_data_n", bus.dataOut, 32'd2);
        check("t2_read_n", {bus.readOut, bus.writeOut}, 2'b10);
        check("t2_unstall", bus.stallOut, 1'b0);
        step();
        check("t2_sel_s", sel, SS);
        check("t2_data_s", bus.dataOut, 32'd3);
        step();
        check("t2_sel_l", sel, SL);
        check("t2_data_l", bus.dataOut, 32'd4);
        step();
        check("t2_empty", sel, S0);
        check("t2_err", bus.errorOut, 1'b0);

        // overflow: drop with acceptIn low, then drop while the head pops
        drive(1'b0, 1'b1, 0, 1, 32'd1, 1'b0);
        step();
        drive(1'b0, 1'b1, 1, 0, 32'd2, 1'b0);
        step();
        drive(1'b0, 1'b1, 1, 2, 32'd3, 1'b0);
        step();
        drive(1'b0, 1'b1, 1, 1, 32'd4, 1'b0);
        step();
        drive(1'b0, 1'b1, 2, 1, 32'h55, 1'b0);
        step();
        check("t3_stall", bus.stallOut, 1'b1);
        check("t3_err", bus.errorOut, 1'b1);
        check("t3_head", bus.dataOut, 32'd1);
        drive(1'b0, 1'b1, 2, 1, 32'h66, 1'b1);
        step();
        check("t3_pop_sel", sel, SN);
        check("t3_pop_stall", bus.stallOut, 1'b0);
        idle(1'b1);
        step();
        check("t3_d3", bus.dataOut, 32'd3);
        step();
        check("t3_d4", bus.dataOut, 32'd4);
        step();
        check("t3_no_drop", sel, S0);
        check("t3_err_sticky", bus.errorOut, 1'b1);
        idle(1'b0);
        do_reset();
        check("t3_err_clr", bus.errorOut, 1'b0);

        // read and write together is never stored
        drive(1'b1, 1'b1, 1, 1, 32'h77, 1'b0);
        step();
        idle(1'b0);
        check("t4_sel", sel, S0);
        check("t4_stall", bus.stallOut, 1'b0);
        check("t4_err", bus.errorOut, 1'b1);
        check("t4_rdwr", {bus.readOut, bus.writeOut}, 2'b00);
        do_reset();

        // streaming ten packets with continuous accept, pointers wrap twice
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 2, 1, 32'(i), 1'b1);
            step();
            check($sformatf("t5_data%0d", i), bus.dataOut, 64'(i));
            check($sformatf("t5_stall%0d", i), {bus.stallOut, sel}, {1'b0, SE});
        end
        idle(1'b1);
        step();
        check("t5_empty", sel, S0);
        check("t5_err", bus.errorOut, 1'b0);

        // reset mid-operation flushes queued entries and clears error
        drive(1'b1, 1'b1, 1, 1, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b1, 0, 1, 32'd11, 1'b0);
        step();
        drive(1'b0, 1'b1, 1, 0, 32'd12, 1'b0);
        step();
        drive(1'b0, 1'b1, 2, 1, 32'd13, 1'b0);
        step();
        check("t6_pre_sel", sel, SW);
        check("t6_pre_err", bus.errorOut, 1'b1);
        drive(1'b0, 1'b1, 2, 1, 32'd14, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle(1'b0);
        check("t6_flush_sel", sel, S0);
        check("t6_flush_err", bus.errorOut, 1'b0);
        check("t6_flush_data", bus.dataOut, 32'h0);
        drive(1'b0, 1'b1, 1, 2, 32'h77, 1'b0);
        step();
        check("t6_new_sel", sel, SS);
        check("t6_new_data", bus.dataOut, 32'h77);
        idle(1'b1);
        step();
        check("t6_drained", sel, S0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
